// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared state encoding and sector geometry for the SD sector buffer
package sd_pkg;

  // Load sequencer states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_INIT = 2'd1,
    ST_REQ       = 2'd2,
    ST_FILL      = 2'd3
  } sd_state_e;

  localparam int          SD_SECTOR_BYTES   = 512;
  localparam logic [31:0] SD_DEFAULT_SECTOR = 32'd16640;
  localparam int          SD_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/sd_word_ram.sv
// rtl/sd_word_ram.sv - single write port, registered read port word RAM for one sector
module sd_word_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [8:0]    i_rindex,
  output logic [31:0]   o_rdata
);

  localparam logic [8:0] DEPTH_IDX = 9'(DEPTH);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Storage array: contents survive reset so a loaded sector is never wiped by it
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; indices past the sector return zero, same-cycle write yields old data
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rdata <= '0;
    end else if (i_rindex < DEPTH_IDX) begin
      r_rdata <= r_mem[i_rindex[AW-1:0]];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sd_sector_buffer.sv
// rtl/sd_sector_buffer.sv - sector load FSM, little-endian byte packer and CPU word read port
module sd_sector_buffer
  import sd_pkg::*;
#(
  parameter int          SECTOR_BYTES   = SD_SECTOR_BYTES,
  parameter logic [31:0] DEFAULT_SECTOR = SD_DEFAULT_SECTOR,
  parameter int          TIMEOUT_CYCLES = SD_TIMEOUT_CYCLES
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_sd_initialized,
  input  logic        i_load_start,
  input  logic [31:0] i_load_sector,
  output logic        o_rd_req,
  output logic [31:0] o_rd_sector,
  input  logic        i_rd_byte_valid,
  input  logic [7:0]  i_rd_byte,
  input  logic        i_rd_complete,
  input  logic [31:0] i_cpu_addr,
  output logic [31:0] o_cpu_rdata,
  output logic        o_buf_valid,
  output logic        o_busy,
  output logic        o_err,
  output logic [9:0]  o_byte_count
);

  localparam int              WORDS      = SECTOR_BYTES / 4;
  localparam int              AW         = $clog2(WORDS);
  localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [9:0]      FULL_COUNT = 10'(SECTOR_BYTES);
  localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  sd_state_e     r_state;
  logic          r_rd_req;
  logic [31:0]   r_rd_sector;
  logic          r_buf_valid;
  logic          r_busy;
  logic          r_err;
  logic [9:0]    r_byte_count;
  logic          r_ovf;
  logic          r_auto_done;
  logic [31:0]   r_word;
  logic [TW-1:0] r_tmo;
  logic          r_cmpl_d;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [31:0]   r_wdata;

  logic          w_auto;
  logic          w_start;
  logic [31:0]   w_start_sector;
  logic          w_byte_in;
  logic          w_byte_acc;
  logic [1:0]    w_lane;
  logic [9:0]    w_cnt_next;
  logic          w_ovf_next;
  logic [31:0]   w_word_next;
  logic          w_cmpl_rise;
  logic          w_unused_addr;

  assign w_auto         = !r_auto_done && i_sd_initialized;
  assign w_start        = (r_state == ST_IDLE) && (i_load_start || w_auto);
  assign w_start_sector = i_load_start ? i_load_sector : DEFAULT_SECTOR;
  assign w_byte_in      = (r_state == ST_FILL) && i_rd_byte_valid;
  assign w_byte_acc     = w_byte_in && (r_byte_count < FULL_COUNT);
  assign w_lane         = r_byte_count[1:0];
  assign w_cnt_next     = r_byte_count + 10'(w_byte_acc);
  assign w_ovf_next     = r_ovf || (w_byte_in && !w_byte_acc);
  assign w_cmpl_rise    = i_rd_complete && !r_cmpl_d;
  assign w_unused_addr  = ^{i_cpu_addr[31:11], i_cpu_addr[1:0]};

  // Merge this cycle's byte into the word being assembled; lane 0 starts a fresh zeroed word
  always_comb begin
    w_word_next = r_word;
    if (w_byte_acc) begin
      if (w_lane == 2'd0) begin
        w_word_next = {24'h0, i_rd_byte};
      end else begin
        w_word_next[8*w_lane +: 8] = i_rd_byte;
      end
    end
  end

  // Remember previous rd_complete so a held level only completes one load
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cmpl_d <= 1'b0;
    end else begin
      r_cmpl_d <= i_rd_complete;
    end
  end

  // Load sequencer: trigger, wait for card, one-cycle request, then pack bytes until done or stalled
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_rd_req     <= 1'b0;
      r_rd_sector  <= '0;
      r_buf_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_byte_count <= '0;
      r_ovf        <= 1'b0;
      r_auto_done  <= 1'b0;
      r_word       <= '0;
      r_tmo        <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      r_rd_req <= 1'b0;
      r_we     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state      <= ST_WAIT_INIT;
            r_busy       <= 1'b1;
            r_rd_sector  <= w_start_sector;
            r_buf_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_byte_count <= '0;
            r_ovf        <= 1'b0;
            r_word       <= '0;
            if (!i_load_start) begin
              r_auto_done <= 1'b1;
            end
          end
        end
        ST_WAIT_INIT: begin
          if (i_sd_initialized) begin
            r_state  <= ST_REQ;
            r_rd_req <= 1'b1;
          end
        end
        ST_REQ: begin
          r_state <= ST_FILL;
          r_tmo   <= '0;
        end
        ST_FILL: begin
          r_byte_count <= w_cnt_next;
          r_ovf        <= w_ovf_next;
          r_word       <= w_word_next;
          r_tmo        <= w_byte_in ? '0 : r_tmo + TW'(1);
          if (w_byte_acc && (w_lane == 2'd3)) begin
            r_we    <= 1'b1;
            r_waddr <= r_byte_count[AW+1:2];
            r_wdata <= w_word_next;
          end
          if (w_cmpl_rise) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if ((w_cnt_next == FULL_COUNT) && !w_ovf_next) begin
              r_buf_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            // A short sector leaves a partial word behind; push it out with zero upper lanes
            if (w_cnt_next[1:0] != 2'd0) begin
              r_we    <= 1'b1;
              r_waddr <= w_cnt_next[AW+1:2];
              r_wdata <= w_word_next;
            end
          end else if (!w_byte_in && (r_tmo == TMO_LAST)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  sd_word_ram #(
    .DEPTH (WORDS),
    .AW    (AW)
  ) u_ram (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_we     (r_we),
    .i_waddr  (r_waddr),
    .i_wdata  (r_wdata),
    .i_rindex (i_cpu_addr[10:2]),
    .o_rdata  (o_cpu_rdata)
  );

  assign o_rd_req     = r_rd_req;
  assign o_rd_sector  = r_rd_sector;
  assign o_buf_valid  = r_buf_valid;
  assign o_busy       = r_busy;
  assign o_err        = r_err;
  assign o_byte_count = r_byte_count;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// tb/tb_sd_sector_buffer.sv - scoreboard bench for the SD sector buffer
module tb_sd_sector_buffer;

  logic        clock;
  logic        reset;
  logic        sd_initialized;
  logic        load_start;
  logic [31:0] load_sector;
  logic        rd_req;
  logic [31:0] rd_sector;
  logic        rd_byte_valid;
  logic [7:0]  rd_byte;
  logic        rd_complete;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_rdata;
  logic        buf_valid;
  logic        busy;
  logic        err;
  logic [9:0]  byte_count;

  sd_sector_buffer #(
    .TIMEOUT_CYCLES (50)
  ) dut (
    .i_clock          (clock),
    .i_reset          (reset),
    .i_sd_initialized (sd_initialized),
    .i_load_start     (load_start),
    .i_load_sector    (load_sector),
    .o_rd_req         (rd_req),
    .o_rd_sector      (rd_sector),
    .i_rd_byte_valid  (rd_byte_valid),
    .i_rd_byte        (rd_byte),
    .i_rd_complete    (rd_complete),
    .i_cpu_addr       (cpu_addr),
    .o_cpu_rdata      (cpu_rdata),
    .o_buf_valid      (buf_valid),
    .o_busy           (busy),
    .o_err            (err),
    .o_byte_count     (byte_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        busy;
    logic        buf_valid;
    logic        err;
    logic [9:0]  byte_count;
    logic [31:0] sector;
  } status_t;

  logic [31:0] rd_q [$];
  status_t     st_q [$];
  logic [31:0] req_q [$];
  logic        rd_issue = 1'b0;
  logic        rd_chk   = 1'b0;
  logic        st_issue = 1'b0;
  logic        st_chk   = 1'b0;
  logic        prev_req = 1'b0;
  status_t     st_e;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) begin
    rd_chk <= rd_issue;
    st_chk <= st_issue;
  end

  always @(negedge clock) begin
    if (rd_chk) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cpu_read_scoreboard actual=read-with-no-expectation required=queued-expectation");
      end else begin
        chk("cpu_rdata", cpu_rdata, rd_q.pop_front());
      end
    end
    if (st_chk) begin
      if (st_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL status_scoreboard actual=sample-with-no-expectation required=queued-expectation");
      end else begin
        st_e = st_q.pop_front();
        chk("busy", 32'(busy), 32'(st_e.busy));
        chk("buf_valid", 32'(buf_valid), 32'(st_e.buf_valid));
        chk("err", 32'(err), 32'(st_e.err));
        chk("byte_count", 32'(byte_count), 32'(st_e.byte_count));
        chk("rd_sector_hold", rd_sector, st_e.sector);
      end
    end
    if (rd_req) begin
      if (prev_req) begin
        checks++; errors++;
        $display("FAIL rd_req_width actual=2+cycles required=1cycle");
      end else if (req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd_req actual=rd_req sector=0x%0h required=no-request", rd_sector);
      end else begin
        chk("rd_sector", rd_sector, req_q.pop_front());
      end
    end
    prev_req = rd_req;
  end

  function automatic logic [7:0] pat(input int i, input int mode);
    int v;
    if (mode == 0) v = i;
    else           v = i + (i >> 8) * 64 + 16;
    return 8'(v);
  endfunction

  task automatic cpu_read(input logic [31:0] a, input logic [31:0] e);
    cpu_addr = a;
    rd_q.push_back(e);
    rd_issue = 1'b1;
    @(negedge clock);
    rd_issue = 1'b0;
  endtask

  task automatic check_status(input logic b, input logic bv, input logic e,
                              input logic [9:0] cnt, input logic [31:0] sec);
    st_q.push_back('{busy: b, buf_valid: bv, err: e, byte_count: cnt, sector: sec});
    st_issue = 1'b1;
    @(negedge clock);
    st_issue = 1'b0;
  endtask

  task automatic load(input logic [31:0] sec);
    req_q.push_back(sec);
    load_sector = sec;
    load_start  = 1'b1;
    @(negedge clock);
    load_start  = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!rd_req && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!rd_req) begin
      errors++;
      $display("FAIL rd_req_wait actual=none-in-%0d-cycles required=rd_req", budget);
    end
    @(negedge clock);
  endtask

  task automatic feed(input int start, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      rd_byte       = pat(start + i, mode);
      rd_byte_valid = 1'b1;
      @(negedge clock);
    end
    rd_byte_valid = 1'b0;
  endtask

  task automatic complete();
    rd_complete = 1'b1;
    @(negedge clock);
    rd_complete = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=still-running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; sd_initialized = 1'b0; load_start = 1'b0; load_sector = '0;
    rd_byte_valid = 1'b0; rd_byte = '0; rd_complete = 1'b0; cpu_addr = '0;
    repeat (2) @(negedge clock);
    cpu_read(32'h0, 32'h0);
    check_status(1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_status(1'b0, 1'b0, 1'b0, 10'd0, 32'd0);

    // auto-load of the default sector on first init, full good sector
    req_q.push_back(32'd16640);
    sd_initialized = 1'b1;
    wait_req(20);
    feed(0, 512, 0);
    complete();
    check_status(1'b0, 1'b1, 1'b0, 10'd512, 32'd16640);
    cpu_read(32'h4,    32'h07060504);
    cpu_read(32'h0,    32'h03020100);
    cpu_read(32'h1FC,  32'hFFFEFDFC);
    cpu_read(32'h8007, 32'h07060504);
    cpu_read(32'h200,  32'h0);
    cpu_read(32'h7FC,  32'h0);

    // short sector: error, partial last word zero-filled
    load(32'd100);
    wait_req(20);
    feed(0, 511, 0);
    complete();
    check_status(1'b0, 1'b0, 1'b1, 10'd511, 32'd100);
    cpu_read(32'h1FC, 32'h00FEFDFC);
    cpu_read(32'h1F8, 32'hFBFAF9F8);

    // overflow: extra bytes dropped, count saturates at 512
    load(32'd200);
    wait_req(20);
    feed(0, 520, 1);
    complete();
    check_status(1'b0, 1'b0, 1'b1, 10'd512, 32'd200);
    cpu_read(32'h0,   32'h13121110);
    cpu_read(32'h1FC, 32'h4F4E4D4C);

    // timeout with no bytes: still busy in cycle 49 of FILL, idle with err in cycle 50
    load(32'd300);
    wait_req(20);
    repeat (48) @(negedge clock);
    check_status(1'b1, 1'b0, 1'b0, 10'd0, 32'd300);
    check_status(1'b0, 1'b0, 1'b1, 10'd0, 32'd300);

    // load_start while busy ignored, strobes in IDLE ignored
    load(32'd400);
    wait_req(20);
    feed(0, 100, 0);
    load_sector = 32'd999;
    load_start  = 1'b1;
    @(negedge clock);
    load_start  = 1'b0;
    feed(100, 412, 0);
    complete();
    check_status(1'b0, 1'b1, 1'b0, 10'd512, 32'd400);
    rd_byte       = 8'hAA;
    rd_byte_valid = 1'b1;
    repeat (8) @(negedge clock);
    rd_byte_valid = 1'b0;
    repeat (2) @(negedge clock);
    cpu_read(32'h0,   32'h03020100);
    cpu_read(32'h1FC, 32'hFFFEFDFC);
    check_status(1'b0, 1'b1, 1'b0, 10'd512, 32'd400);

    // reset mid-FILL, then auto-load re-arms once the card reports init again
    load(32'd500);
    wait_req(20);
    feed(0, 200, 0);
    sd_initialized = 1'b0;
    reset = 1'b1;
    check_status(1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    req_q.push_back(32'd16640);
    sd_initialized = 1'b1;
    wait_req(20);
    feed(0, 512, 0);
    complete();
    check_status(1'b0, 1'b1, 1'b0, 10'd512, 32'd16640);

    repeat (3) @(negedge clock);
    checks++;
    if (req_q.size() != 0) begin
      errors++;
      $display("FAIL missing_rd_req actual=%0d-outstanding required=0", req_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
